// File: rtl/qdrc_arb_pkg.sv
// Shared types for the QDR command arbiter: port IDs, slot pacing and read-tag entries.
// Pure definitions; no latency, no flow control.
package qdrc_arb_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } pend_t;

  // One command slot spans half a burst because QDR moves two beats per cycle.
  function automatic int slot_of(input int burst_length);
    return burst_length / 2;
  endfunction

endpackage

// File: rtl/qdrc_rd_tag_pipe.sv
// Tags in-flight reads with their issuing port and steers returned data back (RD_LATENCY+1 cycles).
// No backpressure: the tag pipe shifts every cycle so reads always drain.
module qdrc_rd_tag_pipe
  import qdrc_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int RD_LATENCY = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  pend_t                   push,
  input  logic [2*DATA_WIDTH-1:0] phy_rd_data,
  output logic [2*DATA_WIDTH-1:0] rd_data,
  output logic                    a_rd_valid,
  output logic                    b_rd_valid
);

  pend_t pipe [RD_LATENCY];
  pend_t tail;

  assign tail = pipe[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe[i] <= '0;
      end
      rd_data    <= '0;
      a_rd_valid <= 1'b0;
      b_rd_valid <= 1'b0;
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
      // The tail lines up with the cycle the PHY presents the matching data beat.
      if (tail.valid) begin
        rd_data <= phy_rd_data;
      end
      a_rd_valid <= tail.valid && (tail.port == PORT_A);
      b_rd_valid <= tail.valid && (tail.port == PORT_B);
    end
  end

endmodule

// File: rtl/qdrc_arbiter.sv
// Round-robin two-port command arbiter feeding the QDR PHY, paced to one command per burst slot.
// Ack is combinational, PHY command 1 cycle later, read return RD_LATENCY+2 after ack; valid held until ack.
module qdrc_arbiter
  import qdrc_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 36,
  parameter int BW_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 21,
  parameter int BURST_LENGTH = 4,
  parameter int RD_LATENCY   = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    phy_rdy,
  input  logic                    a_valid,
  input  logic                    a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [2*DATA_WIDTH-1:0] a_wr_data,
  input  logic [2*BW_WIDTH-1:0]   a_wr_ben,
  output logic                    a_ack,
  output logic                    a_rd_valid,
  input  logic                    b_valid,
  input  logic                    b_we,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [2*DATA_WIDTH-1:0] b_wr_data,
  input  logic [2*BW_WIDTH-1:0]   b_wr_ben,
  output logic                    b_ack,
  output logic                    b_rd_valid,
  output logic [2*DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0]   phy_addr,
  output logic                    phy_wr_strb,
  output logic [2*DATA_WIDTH-1:0] phy_wr_data,
  output logic [2*BW_WIDTH-1:0]   phy_wr_ben,
  output logic                    phy_rd_strb,
  input  logic [2*DATA_WIDTH-1:0] phy_rd_data
);

  localparam int SLOT = slot_of(BURST_LENGTH);

  logic [1:0] slot_cnt;
  logic       slot_last;
  logic       eligible;
  logic       last_grant;
  logic       cmd_port;
  logic       grant_a;
  logic       grant_b;
  pend_t      push;

  assign slot_last = (slot_cnt == 2'(SLOT - 1));
  assign eligible  = !reset && phy_rdy && (slot_cnt == 2'd0);

  // On a tie the port that did not win last time goes next.
  assign grant_a = eligible && a_valid && (!b_valid || (last_grant == PORT_B));
  assign grant_b = eligible && b_valid && (!a_valid || (last_grant == PORT_A));

  assign a_ack = grant_a;
  assign b_ack = grant_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt    <= 2'd0;
      last_grant  <= PORT_B;
      cmd_port    <= PORT_A;
      phy_addr    <= '0;
      phy_wr_data <= '0;
      phy_wr_ben  <= '0;
      phy_wr_strb <= 1'b0;
      phy_rd_strb <= 1'b0;
    end else begin
      if (!phy_rdy || slot_last) begin
        slot_cnt <= 2'd0;
      end else begin
        slot_cnt <= slot_cnt + 2'd1;
      end

      phy_wr_strb <= 1'b0;
      phy_rd_strb <= 1'b0;
      if (grant_a || grant_b) begin
        last_grant  <= grant_b ? PORT_B : PORT_A;
        cmd_port    <= grant_b ? PORT_B : PORT_A;
        phy_addr    <= grant_b ? b_addr : a_addr;
        phy_wr_data <= grant_b ? b_wr_data : a_wr_data;
        phy_wr_ben  <= grant_b ? b_wr_ben : a_wr_ben;
        phy_wr_strb <= grant_b ? b_we : a_we;
        phy_rd_strb <= grant_b ? !b_we : !a_we;
      end
    end
  end

  assign push.valid = phy_rd_strb;
  assign push.port  = cmd_port;

  qdrc_rd_tag_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .phy_rd_data (phy_rd_data),
    .rd_data     (rd_data),
    .a_rd_valid  (a_rd_valid),
    .b_rd_valid  (b_rd_valid)
  );

endmodule

// File: tb/tb_qdrc_arbiter.sv
// Directed bench for qdrc_arbiter: a BL=4/RD_LATENCY=10 instance and a BL=2/RD_LATENCY=4 instance,
// each with a fixed-latency PHY read model returning addr-derived data.
module tb_qdrc_arbiter;

  typedef struct {
    logic        port;
    int          cyc;
    logic [71:0] dat;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          both_rv = 0;

  // Instance 1 (BURST_LENGTH=4, RD_LATENCY=10)
  logic        phy_rdy, a_valid, a_we, b_valid, b_we;
  logic [20:0] a_addr, b_addr, phy_addr;
  logic [71:0] a_wr_data, b_wr_data, rd_data, phy_wr_data, phy_rd_data;
  logic [7:0]  a_wr_ben, b_wr_ben, phy_wr_ben;
  logic        a_ack, b_ack, a_rd_valid, b_rd_valid, phy_wr_strb, phy_rd_strb;

  // Instance 2 (BURST_LENGTH=2, RD_LATENCY=4)
  logic        phy_rdy2, a2_valid, a2_we, b2_valid, b2_we;
  logic [20:0] a2_addr, b2_addr, phy_addr2;
  logic [71:0] a2_wr_data, b2_wr_data, rd_data2, phy_wr_data2, phy_rd_data2;
  logic [7:0]  a2_wr_ben, b2_wr_ben, phy_wr_ben2;
  logic        a2_ack, b2_ack, a2_rd_valid, b2_rd_valid, phy_wr_strb2, phy_rd_strb2;

  ev_t ack_q[$];
  ev_t rd_q[$];
  ev_t ack2_q[$];
  ev_t rd2_q[$];

  logic [21:0] m1 [10] = '{default: '0};
  logic [21:0] m2 [4]  = '{default: '0};

  logic [178:0] outs1, outs2;
  assign outs1 = {a_ack, b_ack, a_rd_valid, b_rd_valid, phy_wr_strb, phy_rd_strb,
                  phy_addr, phy_wr_data, phy_wr_ben, rd_data};
  assign outs2 = {a2_ack, b2_ack, a2_rd_valid, b2_rd_valid, phy_wr_strb2, phy_rd_strb2,
                  phy_addr2, phy_wr_data2, phy_wr_ben2, rd_data2};

  qdrc_arbiter #(.DATA_WIDTH(36), .BW_WIDTH(4), .ADDR_WIDTH(21), .BURST_LENGTH(4), .RD_LATENCY(10)) dut (
    .clk(clk), .reset(reset), .phy_rdy(phy_rdy),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wr_data(a_wr_data), .a_wr_ben(a_wr_ben),
    .a_ack(a_ack), .a_rd_valid(a_rd_valid),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wr_data(b_wr_data), .b_wr_ben(b_wr_ben),
    .b_ack(b_ack), .b_rd_valid(b_rd_valid),
    .rd_data(rd_data), .phy_addr(phy_addr), .phy_wr_strb(phy_wr_strb), .phy_wr_data(phy_wr_data),
    .phy_wr_ben(phy_wr_ben), .phy_rd_strb(phy_rd_strb), .phy_rd_data(phy_rd_data)
  );

  qdrc_arbiter #(.DATA_WIDTH(36), .BW_WIDTH(4), .ADDR_WIDTH(21), .BURST_LENGTH(2), .RD_LATENCY(4)) dut2 (
    .clk(clk), .reset(reset), .phy_rdy(phy_rdy2),
    .a_valid(a2_valid), .a_we(a2_we), .a_addr(a2_addr), .a_wr_data(a2_wr_data), .a_wr_ben(a2_wr_ben),
    .a_ack(a2_ack), .a_rd_valid(a2_rd_valid),
    .b_valid(b2_valid), .b_we(b2_we), .b_addr(b2_addr), .b_wr_data(b2_wr_data), .b_wr_ben(b2_wr_ben),
    .b_ack(b2_ack), .b_rd_valid(b2_rd_valid),
    .rd_data(rd_data2), .phy_addr(phy_addr2), .phy_wr_strb(phy_wr_strb2), .phy_wr_data(phy_wr_data2),
    .phy_wr_ben(phy_wr_ben2), .phy_rd_strb(phy_rd_strb2), .phy_rd_data(phy_rd_data2)
  );

  function automatic logic [71:0] data_of(input logic [20:0] a);
    return {15'h2A5A, a, 15'h1234, a};
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    m1[0] <= {phy_rd_strb, phy_addr};
    for (int i = 1; i < 10; i++) m1[i] <= m1[i-1];
    m2[0] <= {phy_rd_strb2, phy_addr2};
    for (int i = 1; i < 4; i++) m2[i] <= m2[i-1];
  end

  assign phy_rd_data  = m1[9][21] ? data_of(m1[9][20:0]) : 72'hBAD_BAD_BAD_BAD_BAD_BAD;
  assign phy_rd_data2 = m2[3][21] ? data_of(m2[3][20:0]) : 72'hBAD_BAD_BAD_BAD_BAD_BAD;

  always @(negedge clk) begin
    if (a_ack) ack_q.push_back('{port: 1'b0, cyc: cyc, dat: 72'h0});
    if (b_ack) ack_q.push_back('{port: 1'b1, cyc: cyc, dat: 72'h0});
    if (a_rd_valid) rd_q.push_back('{port: 1'b0, cyc: cyc, dat: rd_data});
    if (b_rd_valid) rd_q.push_back('{port: 1'b1, cyc: cyc, dat: rd_data});
    if (a_rd_valid && b_rd_valid) both_rv++;
    if (a2_ack) ack2_q.push_back('{port: 1'b0, cyc: cyc, dat: 72'h0});
    if (a2_rd_valid) rd2_q.push_back('{port: 1'b0, cyc: cyc, dat: rd_data2});
    if (b2_rd_valid) rd2_q.push_back('{port: 1'b1, cyc: cyc, dat: rd_data2});
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n, input string tag);
    int t = 0;
    while (ack_q.size() < n && t < 60) begin
      tick();
      t++;
    end
    chk(tag, ack_q.size() >= n, 1'b1);
  endtask

  // Compares the logged returns against the logged acks: port order, ack+12 timing and model data.
  task automatic chk_returns(input string tag, input int n, input logic first_port,
                             input logic [20:0] addr_a, input logic [20:0] addr_b);
    logic p;
    chk({tag, "_ack_count"}, ack_q.size(), n);
    chk({tag, "_rd_count"}, rd_q.size(), n);
    if (ack_q.size() == n && rd_q.size() == n) begin
      for (int i = 0; i < n; i++) begin
        p = (i % 2 == 0) ? first_port : !first_port;
        chk($sformatf("%s_ack_port%0d", tag, i), ack_q[i].port, p);
        chk($sformatf("%s_rd_port%0d", tag, i), rd_q[i].port, p);
        chk($sformatf("%s_rd_cyc%0d", tag, i), rd_q[i].cyc, ack_q[i].cyc + 12);
        chk($sformatf("%s_rd_dat%0d", tag, i), rd_q[i].dat, data_of(p ? addr_b : addr_a));
        if (i > 0) chk($sformatf("%s_spacing%0d", tag, i), ack_q[i].cyc - ack_q[i-1].cyc, 2);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1;
    phy_rdy = 1'b0; a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_wr_data = '0; a_wr_ben = '0;
    b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wr_data = '0; b_wr_ben = '0;
    phy_rdy2 = 1'b0; a2_valid = 1'b0; a2_we = 1'b0; a2_addr = '0; a2_wr_data = '0; a2_wr_ben = '0;
    b2_valid = 1'b0; b2_we = 1'b0; b2_addr = '0; b2_wr_data = '0; b2_wr_ben = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outs", outs1, '0);
    chk("reset_outs2", outs2, '0);
    tick();
    reset = 1'b0;

    // PHY not ready: request must wait.
    a_valid = 1'b1; a_we = 1'b1; a_addr = 21'h123; a_wr_data = 72'h12_3456_789A_BCDE_F012; a_wr_ben = 8'hA5;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | a_ack | phy_wr_strb | phy_rd_strb;
      tick();
    end
    chk("rdy_low_quiet", seen, 1'b0);
    phy_rdy = 1'b1;
    @(negedge clk);
    chk("first_ack", a_ack, 1'b1);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    chk("first_strobes", {phy_wr_strb, phy_rd_strb}, 2'b10);
    chk("first_addr", phy_addr, 21'h123);
    chk("first_ben", phy_wr_ben, 8'hA5);
    tick();
    @(negedge clk);
    chk("strobe_one_cycle", {phy_wr_strb, phy_rd_strb}, 2'b00);
    tick();

    // Continuous reads from both ports; last grant was A so B leads.
    ack_q.delete(); rd_q.delete();
    a_valid = 1'b1; a_we = 1'b0; a_addr = 21'h10;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 21'h20;
    wait_acks(10, "p2_wait");
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (20) tick();
    chk_returns("p2", 10, 1'b1, 21'h10, 21'h20);

    // Boundary write.
    ack_q.delete(); rd_q.delete();
    a_valid = 1'b1; a_we = 1'b1; a_addr = 21'h1FFFFF; a_wr_data = '1; a_wr_ben = 8'h0F;
    wait_acks(1, "wr_wait");
    a_valid = 1'b0; a_we = 1'b0;
    @(negedge clk);
    chk("wr_strobes", {phy_wr_strb, phy_rd_strb}, 2'b10);
    chk("wr_addr", phy_addr, 21'h1FFFFF);
    chk("wr_ben", phy_wr_ben, 8'h0F);
    chk("wr_data", phy_wr_data, {72{1'b1}});
    repeat (20) tick();
    chk("wr_no_return", rd_q.size(), 0);

    // Five reads then phy_rdy drops; returns must still drain.
    ack_q.delete(); rd_q.delete();
    a_valid = 1'b1; a_addr = 21'h33;
    b_valid = 1'b1; b_addr = 21'h44;
    wait_acks(5, "p4_wait");
    phy_rdy = 1'b0;
    repeat (30) tick();
    chk_returns("p4", 5, 1'b1, 21'h33, 21'h44);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    // Reset with reads in flight.
    ack_q.delete(); rd_q.delete();
    phy_rdy = 1'b1;
    a_valid = 1'b1; a_addr = 21'h55;
    b_valid = 1'b1; b_addr = 21'h66;
    wait_acks(4, "p5_wait");
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("mid_reset_outs", outs1, '0);
    tick();
    reset = 1'b0;
    ack_q.delete(); rd_q.delete();
    a_valid = 1'b1; b_valid = 1'b1;
    @(negedge clk);
    chk("post_reset_tie", {a_ack, b_ack}, 2'b10);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (20) tick();
    chk("post_reset_rd_count", rd_q.size(), 1);
    if (rd_q.size() == 1 && ack_q.size() == 1) begin
      chk("post_reset_rd_port", rd_q[0].port, 1'b0);
      chk("post_reset_rd_cyc", rd_q[0].cyc, ack_q[0].cyc + 12);
      chk("post_reset_rd_dat", rd_q[0].dat, data_of(21'h55));
    end

    // SLOT=1 instance: back-to-back reads from port A.
    ack2_q.delete(); rd2_q.delete();
    phy_rdy2 = 1'b1; a2_valid = 1'b1; a2_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a2_addr = 21'h100 + 21'(k);
      @(negedge clk);
      chk($sformatf("bl2_ack%0d", k), a2_ack, 1'b1);
      if (k > 0) chk($sformatf("bl2_strb%0d", k), phy_rd_strb2, 1'b1);
      tick();
    end
    a2_valid = 1'b0;
    repeat (12) tick();
    chk("bl2_rd_count", rd2_q.size(), 8);
    if (rd2_q.size() == 8 && ack2_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("bl2_rd_cyc%0d", i), rd2_q[i].cyc, ack2_q[i].cyc + 6);
        chk($sformatf("bl2_rd_port%0d", i), rd2_q[i].port, 1'b0);
        chk($sformatf("bl2_rd_dat%0d", i), rd2_q[i].dat, data_of(21'h100 + 21'(i)));
      end
    end

    chk("single_rd_valid", both_rv, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
